muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_if.sv | 30 +++
 rtl/muldiv_unit.sv | 153 +++++++++++++++
 tb/tb_muldiv_unit.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/muldiv_if.sv
// Request/response bundle for muldiv_unit.
//   start  : request pulse, sampled only while the unit is idle
//   op     : operation select (RV32M order: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU)
//   A, B   : operands (dividend/multiplicand, divisor/multiplier)
//   busy   : operation in progress
//   done   : one-cycle pulse, result valid
//   result : registered result, held until the next done or reset
//   zero   : result == 0, registered with result
interface muldiv_if #(
    parameter int unsigned WORD_SIZE = 32
) ();
    logic                 start;
    logic [2:0]           op;
    logic [WORD_SIZE-1:0] A;
    logic [WORD_SIZE-1:0] B;
    logic                 busy;
    logic                 done;
    logic [WORD_SIZE-1:0] result;
    logic                 zero;

    modport master (
        output start, op, A, B,
        input  busy, done, result, zero
    );

    modport slave (
        input  start, op, A, B,
        output busy, done, result, zero
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide unit (RV32M operation set).
//   clk   : single clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : muldiv_if slave (start/op/A/B in, busy/done/result/zero out)
// Fixed latency: start sampled at edge k gives done in the cycle after edge k+WORD_SIZE+1.
// Signed operands are reduced to magnitudes at capture; sign is fixed up in DONE.
module muldiv_unit #(
    parameter int unsigned WORD_SIZE = 32
) (
    input logic      clk,
    input logic      rst_n,
    muldiv_if.slave  bus
);
    localparam int unsigned W    = WORD_SIZE;
    localparam int unsigned CntW = $clog2(WORD_SIZE + 1);

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      op_q, op_d;
    logic [W-1:0]    hi_q, hi_d;    // product high half / partial remainder
    logic [W-1:0]    lo_q, lo_d;    // multiplier -> product low half / dividend -> quotient
    logic [W-1:0]    b_q, b_d;      // multiplicand or divisor magnitude
    logic            neg_q, neg_d;
    logic            dz_q, dz_d;    // divide by zero
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [W-1:0]    result_q, result_d;
    logic            zero_q, zero_d;

    logic            a_sgn_op, b_sgn_op, a_neg, b_neg;
    logic [W-1:0]    a_mag, b_mag;
    logic [W:0]      sum, tmp;
    logic [2*W-1:0]  prod, prod_s;
    logic [W-1:0]    res;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        b_d      = b_q;
        neg_d    = neg_q;
        dz_d     = dz_q;
        done_d   = 1'b0;
        result_d = result_q;
        zero_d   = zero_q;

        // Signed A: MUL, MULH, MULHSU, DIV, REM. Signed B: MUL, MULH, DIV, REM.
        a_sgn_op = ~bus.op[0] | (bus.op == 3'd1);
        b_sgn_op = (bus.op[1:0] == 2'b00) | (bus.op == 3'd1) | (bus.op == 3'd6);
        a_neg    = a_sgn_op & bus.A[W-1];
        b_neg    = b_sgn_op & bus.B[W-1];
        a_mag    = a_neg ? -bus.A : bus.A;
        b_mag    = b_neg ? -bus.B : bus.B;

        // Shift-add step: conditional add of multiplicand, then shift {carry,hi,lo} right.
        sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
        // Restoring divide step: shift next dividend bit into the partial remainder.
        tmp = {hi_q, lo_q[W-1]};

        prod   = {hi_q, lo_q};
        prod_s = neg_q ? -prod : prod;
        res    = '0;

        case (state_q)
            StIdle: begin
                if (bus.start) begin
                    op_d    = bus.op;
                    cnt_d   = CntW'(W);
                    hi_d    = '0;
                    lo_d    = bus.op[2] ? a_mag : b_mag;
                    b_d     = bus.op[2] ? b_mag : a_mag;
                    // REM takes the dividend sign; everything else is the XOR of operand signs.
                    neg_d   = a_neg ^ ((bus.op == 3'd6) ? 1'b0 : b_neg);
                    dz_d    = (bus.B == '0);
                    state_d = StCalc;
                end
            end
            StCalc: begin
                if (!op_q[2]) begin
                    hi_d = sum[W:1];
                    lo_d = {sum[0], lo_q[W-1:1]};
                end else if (tmp >= {1'b0, b_q}) begin
                    hi_d = W'(tmp - {1'b0, b_q});
                    lo_d = {lo_q[W-2:0], 1'b1};
                end else begin
                    hi_d = tmp[W-1:0];
                    lo_d = {lo_q[W-2:0], 1'b0};
                end
                cnt_d = cnt_q - CntW'(1);
                if (cnt_q == CntW'(1)) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                case (op_q)
                    3'd0:          res = prod_s[W-1:0];
                    3'd1, 3'd2,
                    3'd3:          res = prod_s[2*W-1:W];
                    // Quotient of x/0 is all-ones regardless of sign; remainder path
                    // already yields A because the magnitude of A survives unchanged.
                    3'd4, 3'd5:    res = dz_q ? '1 : (neg_q ? -lo_q : lo_q);
                    default:       res = neg_q ? -hi_q : hi_q;
                endcase
                result_d = res;
                zero_d   = (res == '0);
                done_d   = 1'b1;
                state_d  = StIdle;
            end
            default: state_d = StIdle;
        endcase

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            op_q     <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            b_q      <= '0;
            neg_q    <= 1'b0;
            dz_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            zero_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            b_q      <= b_d;
            neg_q    <= neg_d;
            dz_q     <= dz_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
            zero_q   <= zero_d;
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;
    assign bus.zero   = zero_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: expected results are queued at launch and
// popped when done is observed; latency, busy length and pulse width are checked.
module tb_muldiv_unit;
    localparam int unsigned W = 32;
    localparam logic [2:0] OpMul = 3'd0, OpMulh = 3'd1, OpMulhsu = 3'd2, OpMulhu = 3'd3;
    localparam logic [2:0] OpDiv = 3'd4, OpDivu = 3'd5, OpRem = 3'd6, OpRemu = 3'd7;

    typedef struct packed {
        logic [W-1:0] res;
        logic         z;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   tests = 0;
    int   failed = 0;
    exp_t sb[$];

    muldiv_if #(.WORD_SIZE(W)) bus ();
    muldiv_unit #(.WORD_SIZE(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [W-1:0] r);
        exp_t e;
        e.res = r;
        e.z   = (r == '0);
        sb.push_back(e);
    endtask

    // Called at a negedge; returns at the negedge right after the sampling edge.
    task automatic launch(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        bus.op    = op;
        bus.A     = a;
        bus.B     = b;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input logic noise);
        int   lat;
        int   bcnt;
        exp_t e;
        lat  = 0;
        bcnt = bus.busy ? 1 : 0;
        while (!bus.done && lat < 100) begin
            if (noise && lat >= 3 && lat <= 8) begin
                bus.start = 1'b1;
                bus.A     = $urandom;
                bus.B     = $urandom;
                bus.op    = 3'($urandom_range(0, 7));
            end else if (noise && lat == 32) begin
                bus.start = 1'b1;   // sampled while in DONE: must be ignored
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
            lat++;
            if (bus.busy) bcnt++;
        end
        bus.start = 1'b0;
        check({tag, "_latency"}, W'(lat), W'(33));
        check({tag, "_busy_cycles"}, W'(bcnt), W'(33));
        if (sb.size() > 0) begin
            e = sb.pop_front();
        end else begin
            e.res = 'x;
            e.z   = 1'bx;
        end
        check({tag, "_result"}, bus.result, e.res);
        check({tag, "_zero"}, W'(bus.zero), W'(e.z));
        @(negedge clk);
        check({tag, "_done_one_cycle"}, W'(bus.done), W'(0));
        check({tag, "_idle_after"}, W'(bus.busy), W'(0));
        check({tag, "_result_hold"}, bus.result, e.res);
    endtask

    task automatic run_op(input string tag, input logic [2:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] r);
        push(r);
        launch(op, a, b);
        wait_done(tag, 1'b0);
    endtask

    task automatic expect_no_done(input string tag, input int cycles);
        int n;
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (bus.done) n++;
        end
        check(tag, W'(n), W'(0));
    endtask

    initial begin
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.op    = '0;
        bus.A     = '0;
        bus.B     = '0;
        repeat (3) @(negedge clk);
        check("reset_busy", W'(bus.busy), W'(0));
        check("reset_done", W'(bus.done), W'(0));
        check("reset_result", bus.result, W'(0));
        check("reset_zero", W'(bus.zero), W'(1));
        rst_n = 1'b1;
        @(negedge clk);

        run_op("mul_7x6",      OpMul,    32'd7,        32'd6,        32'd42);
        run_op("mulh_m1xm1",   OpMulh,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000);
        run_op("mulhu_max",    OpMulhu,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
        run_op("mulhsu_m1x2",  OpMulhsu, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF);
        run_op("mul_m3x5",     OpMul,    32'hFFFFFFFD, 32'd5,        32'hFFFFFFF1);
        run_op("div_m7_2",     OpDiv,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD);
        run_op("rem_m7_2",     OpRem,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF);
        run_op("divu_439_137", OpDivu,   32'd439,      32'd137,      32'd3);
        run_op("remu_439_137", OpRemu,   32'd439,      32'd137,      32'd28);
        run_op("divu_5_0",     OpDivu,   32'd5,        32'd0,        32'hFFFFFFFF);
        run_op("rem_5_0",      OpRem,    32'd5,        32'd0,        32'd5);
        run_op("div_m5_0",     OpDiv,    32'hFFFFFFFB, 32'd0,        32'hFFFFFFFF);
        run_op("remu_7_0",     OpRemu,   32'd7,        32'd0,        32'd7);
        run_op("div_ovf",      OpDiv,    32'h80000000, 32'hFFFFFFFF, 32'h80000000);
        run_op("rem_ovf",      OpRem,    32'h80000000, 32'hFFFFFFFF, 32'd0);

        // Start and operand churn during CALC, plus start held in the DONE cycle.
        push(32'd42);
        launch(OpMul, 32'd7, 32'd6);
        wait_done("busy_ignore", 1'b1);
        expect_no_done("busy_ignore_no_extra_done", 40);

        // Leave a nonzero result in place, then abort an operation with reset.
        run_op("mul_pre_reset", OpMul, 32'd9, 32'd9, 32'd81);
        launch(OpMul, 32'd11, 32'd13);
        repeat (9) @(negedge clk);
        rst_n     = 1'b0;
        bus.start = 1'b1;   // coincides with reset: must be ignored
        @(negedge clk);
        check("abort_busy", W'(bus.busy), W'(0));
        check("abort_done", W'(bus.done), W'(0));
        check("abort_result", bus.result, W'(0));
        check("abort_zero", W'(bus.zero), W'(1));
        rst_n     = 1'b1;
        bus.start = 1'b0;
        expect_no_done("abort_no_done", 40);
        run_op("mul_3x5_after_abort", OpMul, 32'd3, 32'd5, 32'd15);

        check("scoreboard_empty", W'(sb.size()), W'(0));
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
